// File: rtl/mutex_pkg.sv
// Shared encodings for the mutex value waiter: request modes and FSM states.
package mutex_pkg;

   typedef enum logic [1:0] {
      MODE_DIFF = 2'd0,
      MODE_EQ   = 2'd1,
      MODE_GE   = 2'd2,
      MODE_SNAP = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mutex_value_waiter_if.sv
// Value read port plus client request/response channel of the mutex value waiter.
interface mutex_value_waiter_if #(
   parameter int WITDH = 32,
   parameter int TO_W  = 16
);
   logic [WITDH-1:0] value_i;
   logic             valid_i;
   logic             ready_o;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       req_mode_i;
   logic [WITDH-1:0] req_ref_i;
   logic [TO_W-1:0]  req_timeout_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [WITDH-1:0] rsp_value_o;
   logic             rsp_timeout_o;
   logic [WITDH-1:0] cur_value_o;
   logic             cur_known_o;

   modport master (
      output value_i, valid_i, req_valid_i, req_mode_i, req_ref_i, req_timeout_i, rsp_ready_i,
      input  ready_o, req_ready_o, rsp_valid_o, rsp_value_o, rsp_timeout_o, cur_value_o, cur_known_o
   );

   modport slave (
      input  value_i, valid_i, req_valid_i, req_mode_i, req_ref_i, req_timeout_i, rsp_ready_i,
      output ready_o, req_ready_o, rsp_valid_o, rsp_value_o, rsp_timeout_o, cur_value_o, cur_known_o
   );
endinterface

// File: rtl/mutex_seq_cmp.sv
// Combinational hit test of the shadow value against a reference for all request modes.
module mutex_seq_cmp
   import mutex_pkg::*;
#(
   parameter int WITDH = 32
) (
   input  logic [WITDH-1:0] a,
   input  logic [WITDH-1:0] b,
   input  mode_e            mode,
   input  logic             known,
   output logic             hit
);

   logic [WITDH-1:0] diff;

   // Serial-number compare: a is "at or after" b when the modular distance is in the lower half.
   assign diff = a - b;

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves hit unassigned (no latch).
      hit = 1'b0;
      case (mode)
         MODE_DIFF: hit = known && (a != b);
         MODE_EQ:   hit = known && (a == b);
         MODE_GE:   hit = known && !diff[WITDH-1];
         MODE_SNAP: hit = 1'b1;
         default:   hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/mutex_value_waiter.sv
// Shadows a mutexValue read port and serves one blocking client wait at a time.
module mutex_value_waiter
   import mutex_pkg::*;
#(
   parameter int WITDH = 32,
   parameter int TO_W  = 16
) (
   input logic                core_clk,
   input logic                core_rst_n,
   mutex_value_waiter_if.slave bus
);

   state_e           state;
   logic [WITDH-1:0] shadow;
   logic             known;
   mode_e            mode_q;
   logic [WITDH-1:0] ref_q;
   logic [TO_W-1:0]  cnt;
   logic [WITDH-1:0] rsp_value_q;
   logic             rsp_timeout_q;
   logic             hit;

   mutex_seq_cmp #(.WITDH(WITDH)) u_cmp (
      .a     (shadow),
      .b     (ref_q),
      .mode  (mode_q),
      .known (known),
      .hit   (hit)
   );

   // The shadow follows the read port regardless of FSM state.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         shadow <= '0;
         known  <= 1'b0;
      end else if (bus.valid_i) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         shadow <= bus.value_i;
         known  <= 1'b1;
      end
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state         <= ST_IDLE;
         mode_q        <= MODE_DIFF;
         ref_q         <= '0;
         cnt           <= '0;
         rsp_value_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid_i) begin
                  mode_q <= mode_e'(bus.req_mode_i);
                  ref_q  <= bus.req_ref_i;
                  cnt    <= bus.req_timeout_i;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A hit outranks expiry in the same cycle; cnt == 0 waits forever.
               if (hit) begin
                  rsp_value_q   <= shadow;
                  rsp_timeout_q <= 1'b0;
                  state         <= ST_RESP;
               end else if (cnt == TO_W'(1)) begin
                  rsp_value_q   <= shadow;
                  rsp_timeout_q <= 1'b1;
                  state         <= ST_RESP;
               end else if (cnt != '0) begin
                  cnt <= cnt - TO_W'(1);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o       = 1'b1;
   assign bus.req_ready_o   = (state == ST_IDLE);
   assign bus.rsp_valid_o   = (state == ST_RESP);
   assign bus.rsp_value_o   = rsp_value_q;
   assign bus.rsp_timeout_o = rsp_timeout_q;
   assign bus.cur_value_o   = shadow;
   assign bus.cur_known_o   = known;

endmodule

// File: tb/tb_mutex_value_waiter.sv
// Directed vector table plus hand-written multi-cycle sequences for mutex_value_waiter.
module tb_mutex_value_waiter;

   logic core_clk;
   logic core_rst_n;
   int   n_cmp;
   int   n_fail;

   mutex_value_waiter_if #(.WITDH(32), .TO_W(16)) bus ();

   mutex_value_waiter #(.WITDH(32), .TO_W(16)) dut (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .bus        (bus.slave)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   typedef struct {
      logic        valid;
      logic [31:0] value;
      logic        req;
      logic [1:0]  mode;
      logic [31:0] refv;
      logic [15:0] tmo;
      logic        rsp_rdy;
      logic        e_rsp_valid;
      logic        e_req_ready;
      logic [31:0] e_rsp_value;
      logic        e_rsp_timeout;
      logic [31:0] e_cur;
      logic        e_known;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic valid, input logic [31:0] value, input logic req,
                        input logic [1:0] mode, input logic [31:0] refv,
                        input logic [15:0] tmo, input logic rsp_rdy);
      bus.valid_i       = valid;
      bus.value_i       = value;
      bus.req_valid_i   = req;
      bus.req_mode_i    = mode;
      bus.req_ref_i     = refv;
      bus.req_timeout_i = tmo;
      bus.rsp_ready_i   = rsp_rdy;
   endtask

   task automatic idle_in();
      drive(1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
   endtask

   // One clock edge, then settle before outputs are sampled.
   task automatic step();
      @(posedge core_clk);
      #1;
   endtask

   task automatic do_reset();
      core_rst_n = 1'b0;
      idle_in();
      repeat (2) @(negedge core_clk);
      check("rst_req_ready", bus.req_ready_o, 1);
      check("rst_rsp_valid", bus.rsp_valid_o, 0);
      check("rst_rsp_timeout", bus.rsp_timeout_o, 0);
      check("rst_rsp_value", bus.rsp_value_o, 0);
      check("rst_cur_value", bus.cur_value_o, 0);
      check("rst_cur_known", bus.cur_known_o, 0);
      check("rst_ready_o", bus.ready_o, 1);
      core_rst_n = 1'b1;
      step();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      //          valid value req mode ref tmo rdy | rspv reqr rval rto cur known
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0};
      vecs[1]  = '{0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
      vecs[4]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1};
      vecs[7]  = '{1, 5, 0, 0, 0, 0, 0,   0, 1, 0, 0, 5, 1};
      vecs[8]  = '{0, 0, 1, 0, 5, 0, 0,   0, 0, 0, 0, 5, 1};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 5, 1};
      vecs[10] = '{1, 7, 0, 0, 0, 0, 0,   0, 0, 0, 0, 7, 1};
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0,   1, 0, 7, 0, 7, 1};
      vecs[12] = '{0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 7, 1};

      do_reset();

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].valid, vecs[i].value, vecs[i].req, vecs[i].mode,
               vecs[i].refv, vecs[i].tmo, vecs[i].rsp_rdy);
         step();
         check($sformatf("v%0d_rsp_valid", i), bus.rsp_valid_o, vecs[i].e_rsp_valid);
         check($sformatf("v%0d_req_ready", i), bus.req_ready_o, vecs[i].e_req_ready);
         check($sformatf("v%0d_cur_value", i), bus.cur_value_o, vecs[i].e_cur);
         check($sformatf("v%0d_cur_known", i), bus.cur_known_o, vecs[i].e_known);
         if (vecs[i].e_rsp_valid) begin
            check($sformatf("v%0d_rsp_value", i), bus.rsp_value_o, vecs[i].e_rsp_value);
            check($sformatf("v%0d_rsp_timeout", i), bus.rsp_timeout_o, vecs[i].e_rsp_timeout);
         end
      end
      idle_in();

      // Wrap-aware sequence compare.
      drive(1'b1, 32'hFFFF_FFE0, 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 2'd2, 32'hFFFF_FFF0, 16'h0, 1'b0);
      step();
      idle_in();
      repeat (2) step();
      check("ge_below_waits", bus.rsp_valid_o, 0);
      drive(1'b1, 32'h7FFF_FFF1, 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
      step();
      idle_in();
      repeat (2) step();
      check("ge_far_no_hit", bus.rsp_valid_o, 0);
      check("ge_far_cur", bus.cur_value_o, 32'h7FFF_FFF1);
      drive(1'b1, 32'h0000_0003, 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
      step();
      idle_in();
      check("ge_wrap_not_yet", bus.rsp_valid_o, 0);
      step();
      check("ge_wrap_hit", bus.rsp_valid_o, 1);
      check("ge_wrap_value", bus.rsp_value_o, 3);
      check("ge_wrap_timeout", bus.rsp_timeout_o, 0);
      bus.rsp_ready_i = 1'b1;
      step();
      idle_in();
      step();

      // Timeout expiry: shadow 1, mode EQ ref 9, timeout 4.
      drive(1'b1, 32'h1, 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b1, 2'd1, 32'h9, 16'd4, 1'b0);
      step();
      idle_in();
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("to_edge%0d_rsp_valid", k), bus.rsp_valid_o, (k == 4));
      end
      check("to_timeout_flag", bus.rsp_timeout_o, 1);
      check("to_value", bus.rsp_value_o, 1);
      bus.rsp_ready_i = 1'b1;
      step();
      idle_in();
      check("to_back_idle", bus.req_ready_o, 1);
      step();

      // Timeout 1 with condition already true: hit wins; response held while shadow moves.
      drive(1'b0, 32'h0, 1'b1, 2'd1, 32'h1, 16'd1, 1'b0);
      step();
      idle_in();
      step();
      check("hitwin_rsp_valid", bus.rsp_valid_o, 1);
      check("hitwin_timeout", bus.rsp_timeout_o, 0);
      check("hitwin_value", bus.rsp_value_o, 1);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'd10 + 32'(k), 1'b0, 2'd0, 32'h0, 16'h0, 1'b0);
         step();
         check($sformatf("hold%0d_rsp_valid", k), bus.rsp_valid_o, 1);
         check($sformatf("hold%0d_rsp_value", k), bus.rsp_value_o, 1);
         check($sformatf("hold%0d_cur_value", k), bus.cur_value_o, 32'd10 + 32'(k));
      end
      idle_in();
      bus.rsp_ready_i = 1'b1;
      step();
      idle_in();
      check("hold_release", bus.rsp_valid_o, 0);

      // Snapshot before any value is known.
      do_reset();
      drive(1'b0, 32'h0, 1'b1, 2'd3, 32'd123, 16'h0, 1'b0);
      step();
      idle_in();
      step();
      check("snap_rsp_valid", bus.rsp_valid_o, 1);
      check("snap_value", bus.rsp_value_o, 0);
      check("snap_timeout", bus.rsp_timeout_o, 0);
      check("snap_known", bus.cur_known_o, 0);
      bus.rsp_ready_i = 1'b1;
      step();
      idle_in();

      // Reset while waiting drops the request.
      drive(1'b0, 32'h0, 1'b1, 2'd1, 32'd99, 16'h0, 1'b0);
      step();
      idle_in();
      check("rstwait_in_wait", bus.req_ready_o, 0);
      #2 core_rst_n = 1'b0;
      #1 check("rstwait_async_idle", bus.req_ready_o, 1);
      @(negedge core_clk);
      core_rst_n = 1'b1;
      bus.valid_i = 1'b1;
      bus.value_i = 32'd99;
      step();
      idle_in();
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rstwait%0d_rsp_valid", k), bus.rsp_valid_o, 0);
         check($sformatf("rstwait%0d_req_ready", k), bus.req_ready_o, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
